vga_pmod_monitor: RTL and testbench
===================================

Name: vga_pmod_monitor

Overview:
- Receive-side checker for the TinyVGA PMOD byte that the top-level design drives on uo_out.
- Sits in the verification/bring-up path, fed by a second board or an FPGA twin on the same pixel clock.
- Decodes HSYNC/VSYNC, measures line and frame timing, and computes a per-frame CRC of visible pixels.
- Reports lock status and sticky timing errors.

Parameters:
- H_ACT_START, 144, pixel index after HSYNC leading edge where visible pixels begin (sync plus back porch).
- H_ACTIVE, 640, visible pixels per line.
- V_ACT_START, 35, line index after VSYNC leading edge where visible lines begin.
- V_ACTIVE, 480, visible lines per frame.
- SYNC_ACTIVE_LOW, 1, 1 means sync pulses are low; 0 means high.

Ports:
- clk  in  1  pixel clock; one PMOD sample per cycle.
- rst  in  1  reset.
- pmod_in  in  8  TinyVGA byte: [0]R1 [1]G1 [2]B1 [3]VSYNC [4]R0 [5]G0 [6]B0 [7]HSYNC.
- h_total  out  11  clocks between consecutive HSYNC leading edges.
- h_sync_w  out  11  HSYNC pulse width in clocks.
- v_total  out  10  lines between consecutive VSYNC leading edges.
- v_sync_w  out  10  VSYNC pulse width in lines.
- frame_crc  out  16  CRC of the last completed frame's visible pixels.
- frame_count  out  16  completed frames, wraps at 65535 to 0.
- frame_done  out  1  one-cycle pulse when all results update.
- locked  out  1  two consecutive frames had identical timing.
- err_timing  out  1  sticky flag: timing changed while locked.

Behaviour:
- Clock and reset (already decided): one clock; reset is synchronous and active-high.
- Reset state:
  - All outputs 0.
  - FSM in SEARCH.
  - All counters 0; CRC accumulator 0xFFFF.
  - Asserting rst mid-frame discards the partial frame with no frame_done.
- Input register and sync normalisation:
  - pmod_in is registered once.
  - Syncs are normalised to active-high: hs = bit7 ^ SYNC_ACTIVE_LOW, vs = bit3 ^ SYNC_ACTIVE_LOW.
  - A leading edge is a registered 0->1 transition of hs/vs.
- Horizontal counting:
  - hcnt (11 b) resets to 0 on the cycle an hs leading edge is seen, otherwise increments.
  - hcnt saturates at 2047.
  - On each hs leading edge, hcnt+1 is captured into a line-period register.
  - hs pulse width is counted while hs is high and captured on its falling edge.
- Vertical counting:
  - vcnt (10 b) increments on each hs leading edge and resets to 0 on a vs leading edge.
  - vcnt saturates at 1023.
  - vs width is measured as the number of hs leading edges seen while vs is high.
  - If vs and hs leading edges coincide, the vs reset wins and that line is line 0.
- Visible window:
  - Active when H_ACT_START <= hcnt < H_ACT_START+H_ACTIVE and V_ACT_START <= vcnt < V_ACT_START+V_ACTIVE.
  - Both conditions use the values for the current registered sample.
- CRC:
  - CRC-16-CCITT, poly 0x1021, no reflection, no final XOR.
  - During each active cycle, 6 bits are shifted in MSB first: R1,R0,G1,G0,B1,B0. All 6 bits are processed in one clock, combinationally unrolled.
  - The accumulator reinitialises to 0xFFFF on each vs leading edge, after being captured.
- FSM:
  - SEARCH: wait for the first vs leading edge, then go to MEASURE. No frame_done is issued.
  - MEASURE: on the next vs leading edge:
    - latch outputs;
    - pulse frame_done;
    - increment frame_count;
    - store the timing tuple (h_total, h_sync_w, v_total, v_sync_w) as reference;
    - go to CHECK.
  - CHECK: on each vs leading edge, latch outputs, pulse frame_done and increment frame_count.
    - If the tuple equals the reference: set locked=1 and stay.
    - Otherwise: store the new tuple as reference and stay. If locked was 1, clear locked and set err_timing.
- Output timing:
  - Outputs update in the cycle after the registered vs edge, i.e. latency 2 clocks from the pmod_in change.
  - h_total and h_sync_w report the last line's values at frame end.
  - frame_done is high for exactly one clock.
- Loss of sync:
  - If hcnt saturates (no hs for 2048 clocks), clear locked.
  - If locked was 1 at that point, set err_timing.
  - Return to SEARCH.
  - frame_count and other outputs hold their values.

Test Plan:
- 640x480@60 stimulus (800x525, hsync 96, vsync 2 lines, active-low), 3 frames of all-black pixels -> frame_done on frames 2 and 3 only. Results: h_total=800, h_sync_w=96, v_total=525, v_sync_w=2, frame_count=2. locked=1 after the third vs edge. frame_crc equals the bench's bit-serial model for 307200 zero pixels.
- Same timing, colour bar pattern varying per pixel -> frame_crc matches the model every frame. Flipping a single pixel's G0 in frame 4 changes only frame 4's CRC.
- Locked stream, then one frame with h_total=801 -> locked falls to 0 and err_timing rises to 1 at that frame_done. Next two 800-clock frames -> locked returns to 1; err_timing stays 1.
- SYNC_ACTIVE_LOW=0 instance fed positive-polarity syncs -> same measurements as the first scenario.
- HSYNC held inactive for 3000 clocks while locked -> locked=0, err_timing=1, FSM back in SEARCH. Restored timing -> first frame_done after 2 vs edges.
- rst asserted for 1 cycle mid-frame during CHECK -> all outputs 0 the next cycle, no frame_done for the partial frame, and resync via SEARCH.

Source files
------------

// File: rtl/vga_pmod_monitor_if.sv
// TinyVGA PMOD sample stream into the monitor and the timing/CRC results it reports.
interface vga_pmod_monitor_if;
   logic [7:0]  pmod_in;
   logic [10:0] h_total;
   logic [10:0] h_sync_w;
   logic [9:0]  v_total;
   logic [9:0]  v_sync_w;
   logic [15:0] frame_crc;
   logic [15:0] frame_count;
   logic        frame_done;
   logic        locked;
   logic        err_timing;

   modport master (
      output pmod_in,
      input  h_total, h_sync_w, v_total, v_sync_w, frame_crc, frame_count,
             frame_done, locked, err_timing
   );

   modport slave (
      input  pmod_in,
      output h_total, h_sync_w, v_total, v_sync_w, frame_crc, frame_count,
             frame_done, locked, err_timing
   );
endinterface

// File: rtl/vga_pmod_monitor.sv
// Receive-side checker for a TinyVGA PMOD byte: measures sync timing, CRCs the
// visible pixels of each frame, and tracks lock / sticky timing errors.
module vga_pmod_monitor #(
   parameter int unsigned H_ACT_START     = 144,
   parameter int unsigned H_ACTIVE        = 640,
   parameter int unsigned V_ACT_START     = 35,
   parameter int unsigned V_ACTIVE        = 480,
   parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   vga_pmod_monitor_if.slave  bus
);
   typedef enum logic [1:0] {SEARCH, MEASURE, CHECK} state_t;

   localparam logic [10:0] H_LO  = 11'(H_ACT_START);
   localparam logic [10:0] H_HI  = 11'(H_ACT_START + H_ACTIVE);
   localparam logic [9:0]  V_LO  = 10'(V_ACT_START);
   localparam logic [9:0]  V_HI  = 10'(V_ACT_START + V_ACTIVE);
   localparam logic [10:0] H_MAX = 11'h7FF;
   localparam logic [9:0]  V_MAX = 10'h3FF;

   state_t      state, state_nx;
   logic [7:0]  pmod_q;
   logic        hs, vs, hs_q, vs_q;
   logic        hs_rise, hs_fall, vs_rise, vs_fall;
   logic [10:0] hcnt_q, hcnt, line_len, h_period, h_total_now;
   logic [10:0] hw_cnt, h_sync_live;
   logic [9:0]  vcnt_q, vcnt, frame_lines, vw_cnt, v_sync_live;
   logic [5:0]  pix;
   logic [15:0] crc_acc, crc_nx;
   logic        active, lost, same_tuple;
   logic        report, load_ref, locked_nx, err_nx;
   logic [10:0] ref_h_total, ref_h_sync_w;
   logic [9:0]  ref_v_total, ref_v_sync_w;

   logic [10:0] h_total_q, h_sync_w_q;
   logic [9:0]  v_total_q, v_sync_w_q;
   logic [15:0] frame_crc_q, frame_count_q;
   logic        frame_done_q, locked_q, err_q;

   assign hs      = pmod_q[7] ^ SYNC_ACTIVE_LOW;
   assign vs      = pmod_q[3] ^ SYNC_ACTIVE_LOW;
   assign hs_rise = hs & ~hs_q;
   assign hs_fall = ~hs & hs_q;
   assign vs_rise = vs & ~vs_q;
   assign vs_fall = ~vs & vs_q;
   assign pix     = {pmod_q[0], pmod_q[4], pmod_q[1], pmod_q[5], pmod_q[2], pmod_q[6]};

   // Counter values that belong to the sample currently held in pmod_q.
   assign line_len    = (hcnt_q == H_MAX) ? H_MAX : hcnt_q + 11'd1;
   assign frame_lines = (vcnt_q == V_MAX) ? V_MAX : vcnt_q + 10'd1;
   assign h_total_now = hs_rise ? line_len : h_period;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      hcnt = hcnt_q;
      if (hs_rise)
         hcnt = '0;
      else if (hcnt_q != H_MAX)
         hcnt = hcnt_q + 11'd1;

      vcnt = vcnt_q;
      if (vs_rise)
         vcnt = '0;
      else if (hs_rise && vcnt_q != V_MAX)
         vcnt = vcnt_q + 10'd1;
   end

   assign active = (hcnt >= H_LO) && (hcnt < H_HI) && (vcnt >= V_LO) && (vcnt < V_HI);
   assign lost   = (hcnt == H_MAX);

   // CRC-16-CCITT, six pixel bits per clock, R1 first.
   always_comb begin
      crc_nx = crc_acc;
      for (int i = 5; i >= 0; i--)
         crc_nx = (crc_nx[15] ^ pix[i]) ? ({crc_nx[14:0], 1'b0} ^ 16'h1021)
                                        :  {crc_nx[14:0], 1'b0};
   end

   assign same_tuple = (h_total_now == ref_h_total) && (h_sync_live == ref_h_sync_w) &&
                       (frame_lines == ref_v_total) && (v_sync_live == ref_v_sync_w);

   always_comb begin
      state_nx  = state;
      report    = 1'b0;
      load_ref  = 1'b0;
      locked_nx = locked_q;
      err_nx    = err_q;
      if (lost) begin
         state_nx  = SEARCH;
         locked_nx = 1'b0;
         if (locked_q) err_nx = 1'b1;
      end else if (vs_rise) begin
         unique case (state)
            SEARCH:  state_nx = MEASURE;
            MEASURE: begin
               report   = 1'b1;
               load_ref = 1'b1;
               state_nx = CHECK;
            end
            CHECK: begin
               report = 1'b1;
               if (same_tuple) begin
                  locked_nx = 1'b1;
               end else begin
                  load_ref  = 1'b1;
                  locked_nx = 1'b0;
                  if (locked_q) err_nx = 1'b1;
               end
            end
            default: state_nx = SEARCH;
         endcase
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         pmod_q        <= {SYNC_ACTIVE_LOW, 3'b000, SYNC_ACTIVE_LOW, 3'b000};
         hs_q          <= 1'b0;
         vs_q          <= 1'b0;
         hcnt_q        <= '0;
         vcnt_q        <= '0;
         h_period      <= '0;
         hw_cnt        <= '0;
         h_sync_live   <= '0;
         vw_cnt        <= '0;
         v_sync_live   <= '0;
         crc_acc       <= 16'hFFFF;
         state         <= SEARCH;
         ref_h_total   <= '0;
         ref_h_sync_w  <= '0;
         ref_v_total   <= '0;
         ref_v_sync_w  <= '0;
         h_total_q     <= '0;
         h_sync_w_q    <= '0;
         v_total_q     <= '0;
         v_sync_w_q    <= '0;
         frame_crc_q   <= '0;
         frame_count_q <= '0;
         frame_done_q  <= 1'b0;
         locked_q      <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         pmod_q <= bus.pmod_in;
         hs_q   <= hs;
         vs_q   <= vs;
         hcnt_q <= hcnt;
         vcnt_q <= vcnt;
         if (hs_rise) h_period <= line_len;

         if (hs_rise)
            hw_cnt <= 11'd1;
         else if (hs && hw_cnt != H_MAX)
            hw_cnt <= hw_cnt + 11'd1;
         if (hs_fall) h_sync_live <= hw_cnt;

         // A vs edge coinciding with an hs edge counts that line as the first sync line.
         if (vs_rise)
            vw_cnt <= {9'd0, hs_rise};
         else if (vs && hs_rise && vw_cnt != V_MAX)
            vw_cnt <= vw_cnt + 10'd1;
         if (vs_fall) v_sync_live <= vw_cnt;

         if (vs_rise)
            crc_acc <= 16'hFFFF;
         else if (active)
            crc_acc <= crc_nx;

         state        <= state_nx;
         locked_q     <= locked_nx;
         err_q        <= err_nx;
         frame_done_q <= report;
         if (report) begin
            h_total_q     <= h_total_now;
            h_sync_w_q    <= h_sync_live;
            v_total_q     <= frame_lines;
            v_sync_w_q    <= v_sync_live;
            frame_crc_q   <= crc_acc;
            frame_count_q <= frame_count_q + 16'd1;
         end
         if (load_ref) begin
            ref_h_total  <= h_total_now;
            ref_h_sync_w <= h_sync_live;
            ref_v_total  <= frame_lines;
            ref_v_sync_w <= v_sync_live;
         end
      end
   end

   assign bus.h_total     = h_total_q;
   assign bus.h_sync_w    = h_sync_w_q;
   assign bus.v_total     = v_total_q;
   assign bus.v_sync_w    = v_sync_w_q;
   assign bus.frame_crc   = frame_crc_q;
   assign bus.frame_count = frame_count_q;
   assign bus.frame_done  = frame_done_q;
   assign bus.locked      = locked_q;
   assign bus.err_timing  = err_q;
endmodule

// File: tb/tb_vga_pmod_monitor.sv
// Drives a shrunken VGA raster into an active-low and an active-high sync monitor
// and scoreboards every frame_done against a frame-level reference model.
module tb_vga_pmod_monitor;
   localparam int H_ACT = 12;
   localparam int H_VIS = 20;
   localparam int V_ACT = 4;
   localparam int V_VIS = 10;
   localparam int LINE  = 40;
   localparam int LINES = 18;
   localparam int HSW   = 4;
   localparam int VSW   = 2;

   typedef struct {
      int ht, hsw, vt, vsw, crc, cnt, lk, er;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vga_pmod_monitor_if bus_lo ();
   vga_pmod_monitor_if bus_hi ();

   vga_pmod_monitor #(.H_ACT_START(H_ACT), .H_ACTIVE(H_VIS), .V_ACT_START(V_ACT),
                      .V_ACTIVE(V_VIS), .SYNC_ACTIVE_LOW(1'b1))
      dut_lo (.clk(clk), .rst(rst), .bus(bus_lo.slave));

   vga_pmod_monitor #(.H_ACT_START(H_ACT), .H_ACTIVE(H_VIS), .V_ACT_START(V_ACT),
                      .V_ACTIVE(V_VIS), .SYNC_ACTIVE_LOW(1'b0))
      dut_hi (.clk(clk), .rst(rst), .bus(bus_hi.slave));

   int   total = 0;
   int   bad   = 0;
   exp_t q_lo[$];
   exp_t q_hi[$];

   // Frame-level model state: sync edges seen since (re)acquisition, reference tuple, flags.
   int   m_edges, m_count, m_locked, m_err;
   int   r_ht, r_hsw, r_vt, r_vsw;
   int   p_ht, p_hsw, p_vt, p_vsw, p_crc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic logic [15:0] crc6(input logic [15:0] crc_in, input logic [5:0] c);
      logic [15:0] r;
      logic        fb;
      r = crc_in;
      for (int i = 5; i >= 0; i--) begin
         fb = r[15] ^ c[i];
         r  = {r[14:0], 1'b0};
         if (fb) r = r ^ 16'h1021;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_edges = 0; m_count = 0; m_locked = 0; m_err = 0;
      r_ht = 0; r_hsw = 0; r_vt = 0; r_vsw = 0;
   endtask

   task automatic model_loss();
      if (m_locked != 0) m_err = 1;
      m_locked = 0;
      m_edges  = 0;
   endtask

   task automatic model_vs_edge();
      exp_t e;
      if (m_edges == 0) begin
         m_edges = 1;
      end else begin
         m_count = (m_count + 1) & 16'hFFFF;
         if (m_edges == 1) begin
            r_ht = p_ht; r_hsw = p_hsw; r_vt = p_vt; r_vsw = p_vsw;
         end else if (p_ht == r_ht && p_hsw == r_hsw && p_vt == r_vt && p_vsw == r_vsw) begin
            m_locked = 1;
         end else begin
            r_ht = p_ht; r_hsw = p_hsw; r_vt = p_vt; r_vsw = p_vsw;
            if (m_locked != 0) begin
               m_locked = 0;
               m_err    = 1;
            end
         end
         m_edges = 2;
         e.ht = p_ht; e.hsw = p_hsw; e.vt = p_vt; e.vsw = p_vsw; e.crc = p_crc;
         e.cnt = m_count; e.lk = m_locked; e.er = m_err;
         q_lo.push_back(e);
         q_hi.push_back(e);
      end
   endtask

   task automatic put(input bit hs, input bit vs, input logic [5:0] c);
      @(posedge clk);
      #1;
      bus_lo.pmod_in = {~hs, c[0], c[2], c[4], ~vs, c[1], c[3], c[5]};
      bus_hi.pmod_in = { hs, c[0], c[2], c[4],  vs, c[1], c[3], c[5]};
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_lo_h_total"},     bus_lo.h_total,     0);
      check({tag, "_lo_h_sync_w"},    bus_lo.h_sync_w,    0);
      check({tag, "_lo_v_total"},     bus_lo.v_total,     0);
      check({tag, "_lo_v_sync_w"},    bus_lo.v_sync_w,    0);
      check({tag, "_lo_frame_crc"},   bus_lo.frame_crc,   0);
      check({tag, "_lo_frame_count"}, bus_lo.frame_count, 0);
      check({tag, "_lo_frame_done"},  bus_lo.frame_done,  0);
      check({tag, "_lo_locked"},      bus_lo.locked,      0);
      check({tag, "_lo_err_timing"},  bus_lo.err_timing,  0);
      check({tag, "_hi_frame_count"}, bus_hi.frame_count, 0);
      check({tag, "_hi_locked"},      bus_hi.locked,      0);
      check({tag, "_hi_err_timing"},  bus_hi.err_timing,  0);
   endtask

   // pattern: 0 black, 1 colour bars, 2 random. Blanking carries junk colour on purpose.
   task automatic drive_frame(input int line_len, input int n_lines, input int pattern,
                              input int flip_row, input int flip_col, input int rst_at);
      logic [15:0] crc;
      logic [5:0]  c;
      bit          vis;
      int          idx;
      crc = 16'hFFFF;
      idx = 0;
      model_vs_edge();
      for (int row = 0; row < n_lines; row++) begin
         for (int col = 0; col < line_len; col++) begin
            vis = (row >= V_ACT) && (row < V_ACT + V_VIS) && (col >= H_ACT) && (col < H_ACT + H_VIS);
            case (pattern)
               0:       c = '0;
               1:       c = vis ? 6'(((col - H_ACT) / 5) * 9 + row) : 6'(col + row);
               default: c = 6'($urandom);
            endcase
            if (pattern == 0 && !vis) c = '0;
            if (row == flip_row && col == flip_col) c[2] = ~c[2];
            if (vis) crc = crc6(crc, c);
            put(col < HSW, row < VSW, c);
            if (idx == rst_at) begin
               rst = 1'b1;
               model_reset();
            end else if (rst_at >= 0 && idx == rst_at + 1) begin
               rst = 1'b0;
               check_zero("midframe_rst");
            end
            idx++;
         end
      end
      p_ht = line_len; p_hsw = HSW; p_vt = n_lines; p_vsw = VSW; p_crc = int'(crc);
   endtask

   task automatic cmp(input string tag, input exp_t e, input int ht, input int hsw, input int vt,
                      input int vsw, input int crc, input int cnt, input int lk, input int er);
      check({tag, "_h_total"},     ht,  e.ht);
      check({tag, "_h_sync_w"},    hsw, e.hsw);
      check({tag, "_v_total"},     vt,  e.vt);
      check({tag, "_v_sync_w"},    vsw, e.vsw);
      check({tag, "_frame_crc"},   crc, e.crc);
      check({tag, "_frame_count"}, cnt, e.cnt);
      check({tag, "_locked"},      lk,  e.lk);
      check({tag, "_err_timing"},  er,  e.er);
   endtask

   initial forever begin
      exp_t e;
      @(negedge clk);
      if (bus_lo.frame_done === 1'b1) begin
         if (q_lo.size() == 0) begin
            total++; bad++;
            $display("FAIL lo_frame_done: got unexpected pulse want none");
         end else begin
            e = q_lo.pop_front();
            cmp("lo", e, bus_lo.h_total, bus_lo.h_sync_w, bus_lo.v_total, bus_lo.v_sync_w,
                bus_lo.frame_crc, bus_lo.frame_count, bus_lo.locked, bus_lo.err_timing);
         end
      end
   end

   initial forever begin
      exp_t e;
      @(negedge clk);
      if (bus_hi.frame_done === 1'b1) begin
         if (q_hi.size() == 0) begin
            total++; bad++;
            $display("FAIL hi_frame_done: got unexpected pulse want none");
         end else begin
            e = q_hi.pop_front();
            cmp("hi", e, bus_hi.h_total, bus_hi.h_sync_w, bus_hi.v_total, bus_hi.v_sync_w,
                bus_hi.frame_crc, bus_hi.frame_count, bus_hi.locked, bus_hi.err_timing);
         end
      end
   end

   initial begin
      model_reset();
      p_ht = 0; p_hsw = 0; p_vt = 0; p_vsw = 0; p_crc = 0;
      bus_lo.pmod_in = 8'h88;
      bus_hi.pmod_in = 8'h00;
      rst = 1'b1;
      repeat (3) put(1'b0, 1'b0, '0);
      rst = 1'b0;
      check_zero("reset");
      repeat (10) put(1'b0, 1'b0, '0);

      // Black frames: first edge only acquires, lock after the third edge.
      repeat (3) drive_frame(LINE, LINES, 0, -1, -1, -1);
      // Colour bars and random pixels; one G0 flip in the fourth bar frame.
      drive_frame(LINE, LINES, 1, -1, -1, -1);
      drive_frame(LINE, LINES, 1, -1, -1, -1);
      drive_frame(LINE, LINES, 1, -1, -1, -1);
      drive_frame(LINE, LINES, 1, V_ACT + 3, H_ACT + 7, -1);
      drive_frame(LINE, LINES, 1, -1, -1, -1);
      drive_frame(LINE, LINES, 2, -1, -1, -1);
      drive_frame(LINE, LINES, 2, -1, -1, -1);
      // One longer-line frame while locked, then two nominal frames to relock.
      drive_frame(LINE + 1, LINES, 2, -1, -1, -1);
      drive_frame(LINE, LINES, 2, -1, -1, -1);
      drive_frame(LINE, LINES, 2, -1, -1, -1);
      drive_frame(LINE, LINES, 0, -1, -1, -1);
      // Single-cycle reset in mid-frame, then reacquire and lock.
      drive_frame(LINE, LINES, 2, -1, -1, LINE * 7 + 5);
      repeat (4) drive_frame(LINE, LINES, 2, -1, -1, -1);
      check("pre_loss_lo_locked", bus_lo.locked, m_locked);

      // Loss of hsync while locked.
      model_loss();
      repeat (3000) put(1'b0, 1'b0, '0);
      check("loss_lo_locked",     bus_lo.locked,     m_locked);
      check("loss_lo_err_timing", bus_lo.err_timing, m_err);
      check("loss_hi_locked",     bus_hi.locked,     m_locked);
      check("loss_hi_err_timing", bus_hi.err_timing, m_err);

      repeat (4) drive_frame(LINE, LINES, 2, -1, -1, -1);
      // Closing sync edge so the last full frame is reported.
      model_vs_edge();
      for (int col = 0; col < LINE; col++) put(col < HSW, 1'b1, '0);
      repeat (6) put(1'b0, 1'b0, '0);
      check("lo_results_outstanding", q_lo.size(), 0);
      check("hi_results_outstanding", q_hi.size(), 0);
      check("final_lo_frame_count", bus_lo.frame_count, m_count);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
